// File: rtl/trv32i_bus_responder.sv
// trv32i_bus_responder: TRV32I data-bus slave backed by a byte-lane RAM with programmable wait states
module trv32i_bus_responder #(
    parameter int B_WIDTH     = 32,
    parameter int ADDR_WIDTH  = 10,
    parameter int WAIT_CYCLES = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [31:0]          bus_addr,
    input  logic                 bus_read_en,
    input  logic                 bus_write_en,
    input  logic [B_WIDTH/8-1:0] bus_byte_en,
    input  logic [B_WIDTH-1:0]   bus_write_data,
    output logic [B_WIDTH-1:0]   bus_read_data,
    output logic                 bus_ready,
    output logic                 bus_err
);
    localparam int NB = B_WIDTH / 8;
    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;
    state_t                state;
    logic [3:0]            cnt;
    logic [ADDR_WIDTH-1:0] waddr;
    logic [NB-1:0]         be;
    logic [B_WIDTH-1:0]    wdata;
    logic                  rd, wr, err;
    logic                  req, bad;
    logic [B_WIDTH-1:0]    mem [2**ADDR_WIDTH];
    assign req = bus_read_en | bus_write_en;
    assign bad = (bus_read_en & bus_write_en) | ((bus_addr >> (ADDR_WIDTH + 2)) != 32'd0);
    // ready/err/read_data are registered on the edge that leaves RESP
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state         <= IDLE;
            cnt           <= '0;
            waddr         <= '0;
            be            <= '0;
            wdata         <= '0;
            rd            <= 1'b0;
            wr            <= 1'b0;
            err           <= 1'b0;
            bus_ready     <= 1'b0;
            bus_err       <= 1'b0;
            bus_read_data <= '0;
        end else begin
            bus_ready <= 1'b0;
            bus_err   <= 1'b0;
            case (state)
                IDLE: if (req) begin
                    state <= (WAIT_CYCLES == 0) ? RESP : WAIT;
                    cnt   <= (WAIT_CYCLES == 0) ? 4'd0 : 4'(WAIT_CYCLES - 1);
                    waddr <= bus_addr[ADDR_WIDTH+1:2];
                    be    <= bus_byte_en;
                    wdata <= bus_write_data;
                    rd    <= bus_read_en;
                    wr    <= bus_write_en;
                    err   <= bad;
                end
                WAIT: begin
                    state <= (cnt == '0) ? RESP : WAIT;
                    cnt   <= (cnt == '0) ? cnt : cnt - 1'b1;
                end
                RESP: begin
                    state     <= IDLE;
                    bus_ready <= 1'b1;
                    bus_err   <= err;
                    if (rd) bus_read_data <= err ? '0 : mem[waddr];
                end
                default: state <= IDLE;
            endcase
        end
    end
    always_ff @(posedge clk) begin
        if (rst && state == RESP && wr && !err)
            for (int i = 0; i < NB; i++)
                if (be[i]) mem[waddr][8*i +: 8] <= wdata[8*i +: 8];
    end
endmodule

// File: tb/tb_trv32i_bus_responder.sv
// tb_trv32i_bus_responder: directed checks of the bus responder with one and zero wait states
module tb_trv32i_bus_responder;
    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [31:0] a_addr = '0, b_addr = '0;
    logic        a_rd = 1'b0, a_wr = 1'b0, b_rd = 1'b0, b_wr = 1'b0;
    logic [3:0]  a_be = '0, b_be = '0;
    logic [31:0] a_wd = '0, b_wd = '0;
    logic [31:0] a_rdata, b_rdata;
    logic        a_ready, a_err, b_ready, b_err;
    int          n = 0;
    int          fails = 0;
    int          lat;
    int          seen;
    logic [31:0] exp_b [3];
    always #5 clk = ~clk;
    trv32i_bus_responder #(.B_WIDTH(32), .ADDR_WIDTH(10), .WAIT_CYCLES(1)) u_a (
        .clk(clk), .rst(rst), .bus_addr(a_addr), .bus_read_en(a_rd), .bus_write_en(a_wr),
        .bus_byte_en(a_be), .bus_write_data(a_wd), .bus_read_data(a_rdata),
        .bus_ready(a_ready), .bus_err(a_err)
    );
    trv32i_bus_responder #(.B_WIDTH(32), .ADDR_WIDTH(10), .WAIT_CYCLES(0)) u_b (
        .clk(clk), .rst(rst), .bus_addr(b_addr), .bus_read_en(b_rd), .bus_write_en(b_wr),
        .bus_byte_en(b_be), .bus_write_data(b_wd), .bus_read_data(b_rdata),
        .bus_ready(b_ready), .bus_err(b_err)
    );
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask
    task automatic set_req(input bit u, input logic r, input logic w, input logic [31:0] a,
                           input logic [3:0] be, input logic [31:0] d);
        if (u) begin
            b_rd = r; b_wr = w; b_addr = a; b_be = be; b_wd = d;
        end else begin
            a_rd = r; a_wr = w; a_addr = a; a_be = be; a_wd = d;
        end
    endtask
    // Drive a request #1 after an edge, wait (bounded) for ready, then drop the request.
    task automatic xact(input bit u, input logic r, input logic w, input logic [31:0] a,
                        input logic [3:0] be, input logic [31:0] d, output int l);
        set_req(u, r, w, a, be, d);
        l = 0;
        do begin
            @(posedge clk); #1; l++;
        end while (!(u ? b_ready : a_ready) && l < 20);
        set_req(u, 1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
    endtask
    initial begin
        // reset with requests active
        set_req(0, 1'b1, 1'b1, 32'h10, 4'hF, 32'h1234_5678);
        repeat (3) @(posedge clk);
        #1;
        chk("rst_ready", a_ready, 0);
        chk("rst_err", a_err, 0);
        chk("rst_rdata", a_rdata, 0);
        set_req(0, 1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
        rst = 1'b1;
        seen = 0;
        repeat (4) begin @(posedge clk); #1; seen += a_ready; end
        chk("post_rst_no_ready", seen, 0);
        // full-word write then read, two cycles acceptance-to-ready
        xact(0, 1'b0, 1'b1, 32'h10, 4'hF, 32'hDEAD_BEEF, lat);
        chk("wr10_lat", lat, 3);
        chk("wr10_err", a_err, 0);
        @(posedge clk); #1;
        chk("ready_pulse", a_ready, 0);
        xact(0, 1'b1, 1'b0, 32'h10, 4'h0, 32'h0, lat);
        chk("rd10_lat", lat, 3);
        chk("rd10_data", a_rdata, 32'hDEAD_BEEF);
        chk("rd10_err", a_err, 0);
        // byte lanes
        xact(0, 1'b0, 1'b1, 32'h20, 4'hF, 32'h1122_3344, lat);
        chk("wr_hold_rdata", a_rdata, 32'hDEAD_BEEF);
        xact(0, 1'b0, 1'b1, 32'h20, 4'b0101, 32'hAABB_CCDD, lat);
        xact(0, 1'b1, 1'b0, 32'h20, 4'h0, 32'h0, lat);
        chk("rd20_lanes", a_rdata, 32'h11BB_33DD);
        xact(0, 1'b0, 1'b1, 32'h20, 4'h0, 32'hFFFF_FFFF, lat);
        chk("be0_ready", lat, 3);
        chk("be0_err", a_err, 0);
        xact(0, 1'b1, 1'b0, 32'h22, 4'h0, 32'h0, lat);
        chk("be0_noop", a_rdata, 32'h11BB_33DD);
        // top word in range, first word out of range
        xact(0, 1'b0, 1'b1, 32'hFFC, 4'hF, 32'h5A5A_A5A5, lat);
        xact(0, 1'b1, 1'b0, 32'hFFC, 4'h0, 32'h0, lat);
        chk("rd_top_data", a_rdata, 32'h5A5A_A5A5);
        chk("rd_top_err", a_err, 0);
        xact(0, 1'b1, 1'b0, 32'h1000, 4'h0, 32'h0, lat);
        chk("oor_rd_lat", lat, 3);
        chk("oor_rd_err", a_err, 1);
        chk("oor_rd_data", a_rdata, 0);
        xact(0, 1'b0, 1'b1, 32'h1010, 4'hF, 32'h0, lat);
        chk("oor_wr_err", a_err, 1);
        xact(0, 1'b1, 1'b1, 32'h10, 4'hF, 32'h0, lat);
        chk("both_en_ready", lat, 3);
        chk("both_en_err", a_err, 1);
        xact(0, 1'b1, 1'b0, 32'h10, 4'h0, 32'h0, lat);
        chk("err_no_update", a_rdata, 32'hDEAD_BEEF);
        chk("err_cleared", a_err, 0);
        // zero wait states, held back-to-back reads
        exp_b[0] = 32'hA000_0000;
        exp_b[1] = 32'hB000_0004;
        exp_b[2] = 32'hC000_0008;
        for (int k = 0; k < 3; k++) begin
            xact(1, 1'b0, 1'b1, 32'(4 * k), 4'hF, exp_b[k], lat);
            chk("w0_wr_lat", lat, 2);
        end
        set_req(1, 1'b1, 1'b0, 32'h0, 4'h0, 32'h0);
        for (int k = 0; k < 3; k++) begin
            lat = 0;
            do begin @(posedge clk); #1; lat++; end while (!b_ready && lat < 20);
            chk("b2b_gap", lat, 2);
            chk("b2b_data", b_rdata, exp_b[k]);
            if (k < 2) set_req(1, 1'b1, 1'b0, 32'(4 * (k + 1)), 4'h0, 32'h0);
            else set_req(1, 1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
        end
        // reset during the wait state of a write
        xact(0, 1'b0, 1'b1, 32'h30, 4'hF, 32'h1234_5678, lat);
        set_req(0, 1'b0, 1'b1, 32'h30, 4'hF, 32'hCAFE_F00D);
        @(posedge clk); #1;
        rst = 1'b0;
        #1;
        chk("abort_rdata", a_rdata, 0);
        seen = 0;
        repeat (2) begin @(posedge clk); #1; seen += a_ready; end
        set_req(0, 1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
        rst = 1'b1;
        repeat (4) begin @(posedge clk); #1; seen += a_ready; end
        chk("abort_no_ready", seen, 0);
        xact(0, 1'b1, 1'b0, 32'h30, 4'h0, 32'h0, lat);
        chk("abort_rd_lat", lat, 3);
        chk("abort_prior", a_rdata, 32'h1234_5678);
        $display("== %0d vectors applied, %0d miscompares ==", n, fails);
        $finish;
    end
endmodule
